// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the ALU control word layout, the arbiter FSM states and the opcode legality helper.
package alu_arb_pkg;

    localparam logic [3:0] OPC_LAST_LEGAL = 4'd13;

    typedef struct packed {
        logic       nx;
        logic       ix;
        logic       sx;
        logic       ny;
        logic       iy;
        logic       sy;
        logic [3:0] opcode;
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    function automatic logic opc_illegal(input logic [3:0] opcode);
        return (opcode > OPC_LAST_LEGAL);
    endfunction

endpackage

// File: rtl/alu_arbiter_chk.sv
// Protocol invariants of alu_arbiter, kept apart from the design itself.
module alu_arbiter_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [1:0] req_valid,
    input logic [1:0] req_ready,
    input logic [1:0] resp_valid
);

    a_resp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(resp_valid));

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));

    a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (req_ready & ~req_valid) == 2'b00);

    a_no_accept_while_resp: assert property (@(posedge clk) disable iff (!rst_n)
        !((req_ready != 2'b00) && (resp_valid != 2'b00)));

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The pointer only moves when the owning
// transaction's response completes, not when the grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_r;
    logic last_r;

    // Pick the pointed-to requester first, otherwise the other one.
    always_comb begin
        grant = 2'b00;
        if (ptr_r == 1'b0) begin
            if (req[0]) begin
                grant = 2'b01;
            end else if (req[1]) begin
                grant = 2'b10;
            end else begin
                grant = 2'b00;
            end
        end else begin
            if (req[1]) begin
                grant = 2'b10;
            end else if (req[0]) begin
                grant = 2'b01;
            end else begin
                grant = 2'b00;
            end
        end
    end

    // Remember the last winner; on completion, priority goes to the other side.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r  <= 1'b0;
            last_r <= 1'b0;
        end else begin
            if (grant != 2'b00) begin
                last_r <= grant[1];
            end
            if (advance) begin
                ptr_r <= ~last_r;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters: accept, drive the
// ALU for one cycle from registers, capture the result, then hold it until taken.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_x,
    input  logic [2*DATA_W-1:0] req_y,
    input  logic [19:0]         req_ctrl,
    output logic [1:0]          resp_valid,
    input  logic [1:0]          resp_ready,
    output logic [DATA_W-1:0]   resp_data,
    output logic                resp_zero,
    output logic                resp_err,
    output logic [DATA_W-1:0]   alu_x,
    output logic [DATA_W-1:0]   alu_y,
    output logic [9:0]          alu_ctrl,
    input  logic [DATA_W-1:0]   alu_out,
    input  logic                alu_zero
);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic [1:0]        arb_req_s;
    logic [1:0]        grant_s;
    logic              sel_s;
    logic              accept_s;
    logic              capture_s;
    logic              done_s;
    logic              id_r;
    logic [DATA_W-1:0] req_x_sel_s;
    logic [DATA_W-1:0] req_y_sel_s;
    alu_ctrl_t         req_ctrl_sel_s;
    logic [DATA_W-1:0] alu_x_r;
    logic [DATA_W-1:0] alu_y_r;
    alu_ctrl_t         alu_ctrl_r;
    logic [1:0]        resp_valid_r;
    logic [DATA_W-1:0] resp_data_r;
    logic              resp_zero_r;
    logic              resp_err_r;

    // Requests are only visible to the arbiter while idle, so a grant always means an accept.
    assign arb_req_s = (state_r == IDLE) ? req_valid : 2'b00;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req_s),
        .advance (done_s),
        .grant   (grant_s)
    );

    // Route the granted requester's operands toward the capture registers.
    always_comb begin
        sel_s = grant_s[1];
        if (sel_s) begin
            req_x_sel_s    = req_x[2*DATA_W-1:DATA_W];
            req_y_sel_s    = req_y[2*DATA_W-1:DATA_W];
            req_ctrl_sel_s = req_ctrl[19:10];
        end else begin
            req_x_sel_s    = req_x[DATA_W-1:0];
            req_y_sel_s    = req_y[DATA_W-1:0];
            req_ctrl_sel_s = req_ctrl[9:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state plus the per-cycle strobes for the datapath.
    always_comb begin
        state_nxt_s = state_r;
        req_ready   = 2'b00;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready = grant_s & req_valid;
                if ((grant_s & req_valid) != 2'b00) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                capture_s   = 1'b1;
                state_nxt_s = RESP;
            end
            RESP: begin
                // Only the owner's resp_ready counts.
                if (resp_ready[id_r]) begin
                    done_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand, ownership and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_r         <= 1'b0;
            alu_x_r      <= {DATA_W{1'b0}};
            alu_y_r      <= {DATA_W{1'b0}};
            alu_ctrl_r   <= alu_ctrl_t'(10'd0);
            resp_valid_r <= 2'b00;
            resp_data_r  <= {DATA_W{1'b0}};
            resp_zero_r  <= 1'b0;
            resp_err_r   <= 1'b0;
        end else begin
            // The ALU sees the held operands only during ISSUE; zeros otherwise.
            if (accept_s) begin
                id_r       <= sel_s;
                alu_x_r    <= req_x_sel_s;
                alu_y_r    <= req_y_sel_s;
                alu_ctrl_r <= req_ctrl_sel_s;
            end else if (capture_s) begin
                alu_x_r    <= {DATA_W{1'b0}};
                alu_y_r    <= {DATA_W{1'b0}};
                alu_ctrl_r <= alu_ctrl_t'(10'd0);
            end
            if (capture_s) begin
                resp_valid_r <= id_r ? 2'b10 : 2'b01;
                if (opc_illegal(alu_ctrl_r.opcode)) begin
                    resp_data_r <= {DATA_W{1'b0}};
                    resp_zero_r <= 1'b1;
                    resp_err_r  <= 1'b1;
                end else begin
                    resp_data_r <= alu_out;
                    resp_zero_r <= alu_zero;
                    resp_err_r  <= 1'b0;
                end
            end else if (done_s) begin
                resp_valid_r <= 2'b00;
            end
        end
    end

    assign alu_x      = alu_x_r;
    assign alu_y      = alu_y_r;
    assign alu_ctrl   = alu_ctrl_r;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign resp_zero  = resp_zero_r;
    assign resp_err   = resp_err_r;

endmodule
